// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: request/operand/result bundle between a controller and the add/sub sequencer
interface add_seq_ctrl_if #(parameter int NBYTES = 4);
    localparam int W = 8 * NBYTES;
    logic         i_start;
    logic         i_sub;
    logic [W-1:0] i_op_a;
    logic [W-1:0] i_op_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;
    logic         o_carry_out;
    logic         o_overflow;
    modport slave (
        input  i_start, i_sub, i_op_a, i_op_b,
        output o_busy, o_done, o_result, o_carry_out, o_overflow
    );
    modport master (
        output i_start, i_sub, i_op_a, i_op_b,
        input  o_busy, o_done, o_result, o_carry_out, o_overflow
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: byte-serial multi-precision add/subtract sequencer over one shared 8-bit ripple adder
module add_seq_rca8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);
    logic [8:0] w_c;
    assign w_c[0] = Cin;
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    assign Cout = w_c[8];
endmodule

module add_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input logic           i_clk,
    input logic           i_rst,
    add_seq_ctrl_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        r_state, w_next;
    logic [W-1:0]  r_a, r_b, r_result;
    logic [IW-1:0] r_idx;
    logic          r_carry, r_co, r_ov, r_busy, r_done;
    logic [7:0]    w_a, w_b, w_s;
    logic          w_cout, w_last;
    assign w_a    = r_a[8*r_idx +: 8];
    assign w_b    = r_b[8*r_idx +: 8];
    assign w_last = r_idx == IW'(NBYTES - 1);
    add_seq_rca8 u_add (.A(w_a), .B(w_b), .Cin(r_carry), .S(w_s), .Cout(w_cout));
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && bus.i_start) ? RUN  :
                 (r_state == RUN && w_last)       ? DONE :
                 (r_state == DONE)                ? IDLE : r_state;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != IDLE;
            r_done  <= w_next == DONE;
        end
    end
    // B is stored pre-inverted and carry seeded with Sub, so subtraction is A + ~B + 1
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_co     <= 1'b0;
            r_ov     <= 1'b0;
        end else if (r_state == IDLE && bus.i_start) begin
            r_a      <= bus.i_op_a;
            r_b      <= bus.i_sub ? ~bus.i_op_b : bus.i_op_b;
            r_carry  <= bus.i_sub;
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == RUN) begin
            r_result[8*r_idx +: 8] <= w_s;
            r_carry                <= w_cout;
            if (w_last) begin
                r_co <= w_cout;
                r_ov <= (w_a[7] == w_b[7]) && (w_s[7] != w_a[7]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_result    = r_result;
    assign bus.o_carry_out = r_co;
    assign bus.o_overflow  = r_ov;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed vectors plus a cycle-level arithmetic model of the add/sub sequencer
module tb_add_seq_ctrl;
    localparam int NB = 4;
    localparam int W  = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   m_ph  = 0;
    logic [W-1:0] m_res = '0;
    logic         m_co  = 1'b0;
    logic         m_ov  = 1'b0;
    logic [W+1:0] m_exp = '0;
    add_seq_ctrl_if #(.NBYTES(NB)) bus();
    add_seq_ctrl #(.NBYTES(NB)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Returns {carry, overflow, result} from signed/unsigned integer arithmetic
    function automatic logic [W+1:0] arith(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sr = s ? sa - sb : sa + sb;
        logic   c  = s ? (ua >= ub) : ((ua + ub) > 64'sh0FFFFFFFF);
        logic   o  = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
        return {c, o, sr[W-1:0]};
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            m_ph  <= 0;
            m_res <= '0;
            m_co  <= 1'b0;
            m_ov  <= 1'b0;
        end else if (m_ph == 0) begin
            if (bus.i_start) begin
                m_exp <= arith(bus.i_op_a, bus.i_op_b, bus.i_sub);
                m_res <= '0;
                m_ph  <= 1;
            end
        end else if (m_ph == NB + 1) begin
            m_ph <= 0;
        end else begin
            m_ph <= m_ph + 1;
            if (m_ph == NB) {m_co, m_ov, m_res} <= m_exp;
        end
    end
    always @(negedge clk) begin
        check("busy", 64'(bus.o_busy), 64'(m_ph != 0));
        check("done", 64'(bus.o_done), 64'(m_ph == NB + 1));
        if (m_ph == 0 || m_ph == NB + 1) begin
            check("model result", 64'(bus.o_result), 64'(m_res));
            check("model carry", 64'(bus.o_carry_out), 64'(m_co));
            check("model overflow", 64'(bus.o_overflow), 64'(m_ov));
        end
    end
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] er, input logic ec, input logic eo);
        int k;
        bus.i_start = 1'b1;
        bus.i_op_a  = a;
        bus.i_op_b  = b;
        bus.i_sub   = s;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_op_a  = $urandom;
        bus.i_op_b  = $urandom;
        bus.i_sub   = ~s;
        k = 1;
        while (!bus.o_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, 64'(k), 64'(NB + 1));
        check({name, " result"}, 64'(bus.o_result), 64'(er));
        check({name, " carry"}, 64'(bus.o_carry_out), 64'(ec));
        check({name, " overflow"}, 64'(bus.o_overflow), 64'(eo));
        @(negedge clk);
    endtask
    task automatic check_zero(input string name);
        check({name, " busy"}, 64'(bus.o_busy), 64'd0);
        check({name, " done"}, 64'(bus.o_done), 64'd0);
        check({name, " result"}, 64'(bus.o_result), 64'd0);
        check({name, " carry"}, 64'(bus.o_carry_out), 64'd0);
        check({name, " overflow"}, 64'(bus.o_overflow), 64'd0);
    endtask
    initial begin
        int nd;
        int k;
        bus.i_start = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_op_a  = '0;
        bus.i_op_b  = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        do_op("ff+1", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
        do_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        do_op("sovf add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        do_op("5-7", 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sovf sub", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        nd = 0;
        bus.i_start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            bus.i_op_a = 32'h01010101 * (c + 1);
            bus.i_op_b = 32'h10203040 + c * 32'h00F00F01;
            bus.i_sub  = c[0];
            @(negedge clk);
            if (bus.o_done) nd++;
        end
        bus.i_start = 1'b0;
        check("held start done count", 64'(nd), 64'd3);
        k = 0;
        while (bus.o_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        bus.i_start = 1'b1;
        bus.i_op_a  = 32'hAAAA5555;
        bus.i_op_b  = 32'h5555AAAA;
        bus.i_sub   = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid-run reset");
        rst = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_done) nd++;
        end
        check("no done after reset", 64'(nd), 64'd0);
        do_op("post reset", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);
        do_op("b2b add", 32'hDEADBEEF, 32'h01020304, 1'b0, 32'hDFAFC1F3, 1'b0, 1'b0);
        do_op("b2b sub", 32'hDEADBEEF, 32'h01020304, 1'b1, 32'hDDABBBEB, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
